// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core-wide constants and the fetch buffer entry type.
//               XLEN       - architectural register / address width
//               RESET_PC   - architectural PC after reset
//               IMEM_BASE  - byte offset of the instruction region in the
//                            unified memory
//               INST_BYTES - size of one instruction word in bytes
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned     XLEN       = 32;
    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] IMEM_BASE  = 32'd256;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    // One prefetched instruction together with its PC and fall-through PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Force an address onto an instruction-word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(INST_BYTES - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Registered circular buffer holding prefetched instructions.
//               The head entry is presented combinationally from storage.
//               Flush empties the buffer and takes priority over push/pop.
// Ports       : clk        in   system clock
//               rst        in   synchronous active-high reset
//               push       in   write push_data at the tail
//               push_data  in   entry to write (WIDTH bits)
//               pop        in   retire the head entry
//               flush      in   discard every entry
//               empty      out  no entry stored
//               count      out  number of stored entries (0..DEPTH)
//               head       out  oldest stored entry (undefined when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic w_do_push;
    logic w_do_pop;

    // Pop only a stored entry; push is accepted when there is room or when
    // the head is leaving in the same cycle (full-and-streaming case).
    assign w_do_pop  = pop & (count_q != '0);
    assign w_do_push = push & (w_do_pop | (count_q != CNT_W'(DEPTH)));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage with a small prefetch buffer feeding
//               the IF/ID register. Issues one word read at a time to the
//               unified memory, buffers {pc, pc+4, inst} entries and hands
//               them to decode on a valid/ready handshake. Redirect and halt
//               flush the buffer and kill the in-flight response.
// Ports       : clk          in   system clock
//               rst          in   synchronous active-high reset
//               mem_req      out  instruction read request
//               mem_addr     out  byte address (fetch_pc + IMEM_BASE)
//               mem_gnt      in   arbiter grant
//               mem_rdata    in   read data, valid the cycle after acceptance
//               redirect     in   taken branch / jump
//               redirect_pc  in   redirect target PC
//               halt         in   EXIT decoded, sticky stop
//               inst_ready   in   decode can accept
//               inst_valid   out  head entry valid
//               inst         out  head instruction (0 when not valid)
//               inst_pc      out  head PC (0 when not valid)
//               inst_pc4     out  head PC+4 (0 when not valid)
//               halted       out  sticky halt status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] IMEM_BASE = riscv_pkg::IMEM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        halted
);

    import riscv_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q,   req_pc_d;
    logic            inflight_q, inflight_d;
    logic            halted_q,   halted_d;

    logic             w_redirect;
    logic             w_kill;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occupancy;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // A redirect arriving after the halt has no effect until reset.
    assign w_redirect = redirect & ~halted_q;

    // Kill covers both the buffered entries and the response returning this
    // cycle: the read it answers was issued on the old path.
    assign w_kill = halt | w_redirect;

    // Slots already spoken for: stored entries plus the one still in memory.
    // Counting the in-flight read guarantees the buffer can never overflow.
    assign w_occupancy = {1'b0, w_count} + OCC_W'(inflight_q);

    assign mem_req  = ~rst & ~halted_q & ~halt & ~redirect
                    & (w_occupancy < OCC_W'(DEPTH));
    assign mem_addr = rst ? '0 : (fetch_pc_q + IMEM_BASE);
    assign w_accept = mem_req & mem_gnt;

    // The response is pushed in the cycle after acceptance, tagged with the
    // PC captured in req_pc_q when the read was accepted.
    assign w_push = inflight_q & ~w_kill & ~rst;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.pc   = req_pc_q;
        w_push_entry.pc4  = req_pc_q + INST_BYTES;
        w_push_entry.inst = mem_rdata;
    end

    assign inst_valid = ~rst & ~halted_q & ~w_empty;
    assign w_pop      = inst_valid & inst_ready & ~redirect & ~halt;

    assign inst     = inst_valid ? w_head.inst : '0;
    assign inst_pc  = inst_valid ? w_head.pc   : '0;
    assign inst_pc4 = inst_valid ? w_head.pc4  : '0;
    assign halted   = halted_q;

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_kill),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    // Halt outranks redirect, which outranks normal sequential fetch. Since
    // mem_req is low during halt/redirect, no read is accepted in those
    // cycles, so inflight_d simply mirrors the acceptance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        halted_d   = halted_q;
        inflight_d = w_accept;
        if (halt) begin
            halted_d = 1'b1;
        end else if (w_redirect) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (w_accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + INST_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

endmodule
`default_nettype wire
